pixel_frame_tx: RTL

PIXEL_FRAME_TX -- requirements
Module: pixel_frame_tx

---
 rtl/pixel_frame_tx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_tx.sv
// Streams one IMG_WIDTH x IMG_HEIGHT frame from a 1-cycle-latency frame buffer over a valid/ready pixel port.
// Define PIXEL_TX_LINE_GAP_EN to insert LINE_GAP idle cycles after every line except the last.
module pixel_frame_tx #(
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int DATA_W     = 8,
  parameter int LINE_GAP   = 4,
  localparam int AW = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
`ifdef PIXEL_TX_LINE_GAP_EN
    ST_GAP,
`endif
    ST_DONE
  } state_e;

  // A line gap is a count of idle cycles, so a negative value is never meaningful.
  if (LINE_GAP < 0) begin : g_line_gap_invalid
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eol_q, out_eol_d;
  logic                out_eof_q, out_eof_d;
  logic                busy_q, busy_d;

`ifdef PIXEL_TX_LINE_GAP_EN
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
`endif

  logic col_last;
  logic row_last;

  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    busy_d      = busy_q;
`ifdef PIXEL_TX_LINE_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_READ;
        end
      end

      ST_READ: state_d = ST_WAIT;

      ST_WAIT: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        out_sof_d   = (col_q == '0) && (row_q == '0);
        out_eol_d   = col_last;
        out_eof_d   = col_last && row_last;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_sof_d   = 1'b0;
          out_eol_d   = 1'b0;
          out_eof_d   = 1'b0;
          if (out_eof_q) begin
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            // The last pixel never advances, so counters and address cannot wrap.
            addr_d = addr_q + 1'b1;
            if (col_last) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
`ifdef PIXEL_TX_LINE_GAP_EN
            if (out_eol_q && (LINE_GAP > 0)) begin
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end else begin
              state_d = ST_READ;
            end
`else
            state_d = ST_READ;
`endif
          end
        end
      end

`ifdef PIXEL_TX_LINE_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == GW'(LINE_GAP - 1)) begin
          state_d = ST_READ;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PIXEL_TX_LINE_GAP_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      busy_q      <= busy_d;
`ifdef PIXEL_TX_LINE_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign mem_rd    = (state_q == ST_READ);
  assign mem_addr  = addr_q;
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign busy      = busy_q;

endmodule
